// File: rtl/masked_and_driver_if.sv
// Share bus between the masked AND driver and the 3-share gadget.
// The gadget keeps its own enable-edge counter and has no reset.
interface masked_and_driver_if #(
   parameter int D = 3
);
   localparam int RW = D * (D - 1) / 2;

   logic [D-1:0]  ina;
   logic [D-1:0]  inb;
   logic [RW-1:0] rin;
   logic          AndEnable;
   logic          AndDone;
   logic [D-1:0]  and_out;

   modport master (
      output ina,
      output inb,
      output rin,
      output AndEnable,
      input  AndDone,
      input  and_out
   );

   modport slave (
      input  ina,
      input  inb,
      input  rin,
      input  AndEnable,
      output AndDone,
      output and_out
   );
endinterface

// File: rtl/masked_and_driver.sv
// Initiator for a 3-share masked AND gadget: share encoding, gadget
// randomness, enable sequencing and counter realignment after reset.
module masked_and_driver #(
   parameter int          D         = 3,
   parameter logic [31:0] LFSR_SEED = 32'hACE12468
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_a,
   input  logic         in_b,
   output logic         res_valid,
   input  logic         res_ready,
   output logic         res_out,
   output logic [D-1:0] res_shares,
   output logic         sync_err,
   masked_and_driver_if.master gad
);
   localparam int          RW   = D * (D - 1) / 2;
   localparam logic [31:0] TAPS = 32'h80200003;
   localparam logic [31:0] SEED =
      (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;

   if (D != 3) begin : g_d_check
      $error("masked_and_driver supports only D = 3");
   end

   typedef enum logic [2:0] {
      FLUSH_PULSE,
      FLUSH_CHECK,
      IDLE,
      RUN,
      CHECK,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   lfsr_q, lfsr_d;
   logic [D-1:0]  ina_q, ina_d;
   logic [D-1:0]  inb_q, inb_d;
   logic [RW-1:0] rin_q, rin_d;
   logic [D-1:0]  rsh_q, rsh_d;
   logic          en_q, en_d;
   logic          rdy_q, rdy_d;
   logic          rv_q, rv_d;
   logic          rout_q, rout_d;
   logic          serr_q, serr_d;
   logic [1:0]    ecnt_q, ecnt_d;

   logic [D-1:0]  enc_a;
   logic [D-1:0]  enc_b;
   logic [RW-1:0] enc_r;

   // Top share carries the value, the lower two are pure mask bits.
   assign enc_a = {in_a ^ lfsr_q[0] ^ lfsr_q[1], lfsr_q[0], lfsr_q[1]};
   assign enc_b = {in_b ^ lfsr_q[2] ^ lfsr_q[3], lfsr_q[2], lfsr_q[3]};
   assign enc_r = lfsr_q[6:4];

   always_comb begin
      state_d = state_q;
      lfsr_d  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'd0);
      ina_d   = ina_q;
      inb_d   = inb_q;
      rin_d   = rin_q;
      rsh_d   = rsh_q;
      en_d    = en_q;
      rdy_d   = rdy_q;
      rv_d    = rv_q;
      rout_d  = rout_q;
      serr_d  = 1'b0;
      ecnt_d  = ecnt_q;
      unique case (state_q)
         FLUSH_PULSE: begin
            ina_d = '0;
            inb_d = '0;
            rin_d = '0;
            // Entered with enable low after reset or a sync error.
            if (!en_q) begin
               en_d = 1'b1;
            end else begin
               en_d    = 1'b0;
               state_d = FLUSH_CHECK;
            end
         end
         FLUSH_CHECK: begin
            if (gad.AndDone) begin
               rdy_d   = 1'b1;
               state_d = IDLE;
            end else begin
               en_d    = 1'b1;
               state_d = FLUSH_PULSE;
            end
         end
         IDLE: begin
            if (in_valid) begin
               ina_d   = enc_a;
               inb_d   = enc_b;
               rin_d   = enc_r;
               en_d    = 1'b1;
               rdy_d   = 1'b0;
               ecnt_d  = 2'd0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (ecnt_q == 2'd2) begin
               en_d    = 1'b0;
               state_d = CHECK;
            end else begin
               ecnt_d = ecnt_q + 2'd1;
            end
         end
         CHECK: begin
            ina_d = '0;
            inb_d = '0;
            rin_d = '0;
            if (gad.AndDone) begin
               rsh_d   = gad.and_out;
               rout_d  = ^gad.and_out;
               rv_d    = 1'b1;
               state_d = DONE;
            end else begin
               serr_d  = 1'b1;
               state_d = FLUSH_PULSE;
            end
         end
         DONE: begin
            if (res_ready) begin
               rv_d    = 1'b0;
               rdy_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            en_d    = 1'b0;
            state_d = FLUSH_PULSE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FLUSH_PULSE;
         lfsr_q  <= SEED;
         ina_q   <= '0;
         inb_q   <= '0;
         rin_q   <= '0;
         rsh_q   <= '0;
         en_q    <= 1'b0;
         rdy_q   <= 1'b0;
         rv_q    <= 1'b0;
         rout_q  <= 1'b0;
         serr_q  <= 1'b0;
         ecnt_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         ina_q   <= ina_d;
         inb_q   <= inb_d;
         rin_q   <= rin_d;
         rsh_q   <= rsh_d;
         en_q    <= en_d;
         rdy_q   <= rdy_d;
         rv_q    <= rv_d;
         rout_q  <= rout_d;
         serr_q  <= serr_d;
         ecnt_q  <= ecnt_d;
      end
   end

   assign in_ready      = rdy_q;
   assign res_valid     = rv_q;
   assign res_out       = rout_q;
   assign res_shares    = rsh_q;
   assign sync_err      = serr_q;
   assign gad.ina       = ina_q;
   assign gad.inb       = inb_q;
   assign gad.rin       = rin_q;
   assign gad.AndEnable = en_q;
endmodule

// File: tb/tb_masked_and_driver.sv
// Bench for masked_and_driver with a reset-less 3-share gadget model.
// Expected shares come from an independent LFSR and ISW reference.
`timescale 1ns/1ps
module tb_masked_and_driver;
   localparam int          D    = 3;
   localparam logic [31:0] SEED = 32'hACE12468;
   localparam logic [31:0] TAPS = 32'h80200003;

   logic         clk       = 1'b0;
   logic         rst       = 1'b1;
   logic         in_valid  = 1'b0;
   logic         in_a      = 1'b0;
   logic         in_b      = 1'b0;
   logic         res_ready = 1'b0;
   logic         in_ready;
   logic         res_valid;
   logic         res_out;
   logic         sync_err;
   logic [D-1:0] res_shares;

   int          n_chk      = 0;
   int          n_pass     = 0;
   int          gcnt       = 0;
   int          preset_val = 0;
   logic        preset_req = 1'b0;
   logic        force_nd   = 1'b0;
   logic [31:0] mlfsr      = SEED;
   logic [7:0]  seen_ina   = '0;

   masked_and_driver_if #(.D(D)) gif ();

   masked_and_driver #(.D(D), .LFSR_SEED(SEED)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_out   (res_out),
      .res_shares(res_shares),
      .sync_err  (sync_err),
      .gad       (gif)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] isw(input logic [2:0] a,
                                      input logic [2:0] b,
                                      input logic [2:0] r);
      logic [2:0] c;
      c[0] = (a[0] & b[0]) ^ r[0] ^ r[1];
      c[1] = (a[1] & b[1]) ^ (r[0] ^ (a[0] & b[1]) ^ (a[1] & b[0])) ^ r[2];
      c[2] = (a[2] & b[2]) ^ (r[1] ^ (a[0] & b[2]) ^ (a[2] & b[0]))
           ^ (r[2] ^ (a[1] & b[2]) ^ (a[2] & b[1]));
      return c;
   endfunction

   // Gadget: counts enabled edges mod 3, result on the wrapping edge.
   always @(posedge clk) begin
      if (preset_req) begin
         gcnt <= preset_val;
      end else if (gif.AndEnable) begin
         if (gcnt == 2) begin
            gcnt        <= 0;
            gif.and_out <= isw(gif.ina, gif.inb, gif.rin);
         end else begin
            gcnt <= gcnt + 1;
         end
      end
   end

   assign gif.AndDone = (gcnt == 0) && !force_nd;

   always @(posedge clk)
      mlfsr <= rst ? SEED : ((mlfsr >> 1) ^ (mlfsr[0] ? TAPS : 32'd0));

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_flush(input int exp_p, input int cyc0, input int p0);
      int cyc;
      int p;
      cyc = cyc0;
      p   = p0;
      while (!in_ready && cyc < 40) begin
         tick();
         cyc++;
         if (gif.AndEnable) p++;
      end
      chk("flush_pulses", p, exp_p);
      chk("flush_ready_cyc", cyc, 2 * exp_p + 1);
   endtask

   task automatic do_reset(input int gpre);
      rst        = 1'b1;
      preset_val = gpre;
      preset_req = 1'b1;
      tick();
      preset_req = 1'b0;
      tick();
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_res_valid", 32'(res_valid), 0);
      chk("rst_res", 32'({res_out, res_shares, sync_err}), 0);
      chk("rst_bus", 32'({gif.ina, gif.inb, gif.rin, gif.AndEnable}), 0);
      rst = 1'b0;
      wait_flush(gpre == 0 ? 3 : 3 - gpre, 0, 0);
   endtask

   task automatic do_op(input logic a, input logic b,
                        input int hold, input int gap);
      logic [31:0] r;
      logic [2:0]  ea, eb, er, es, sh;
      logic        ro;
      int          lat, en_n, w;
      res_ready = (hold == 0);
      for (int i = 0; i < gap; i++) tick();
      w = 0;
      while (!in_ready && w < 40) begin
         tick();
         w++;
      end
      chk("accept_ready", 32'(in_ready), 1);
      r  = mlfsr;
      ea = {a ^ r[0] ^ r[1], r[0], r[1]};
      eb = {b ^ r[2] ^ r[3], r[2], r[3]};
      er = r[6:4];
      es = isw(ea, eb, er);
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("ina", 32'(gif.ina), 32'(ea));
      chk("inb", 32'(gif.inb), 32'(eb));
      chk("rin", 32'(gif.rin), 32'(er));
      chk("ina_xor", 32'(^gif.ina), 32'(a));
      chk("inb_xor", 32'(^gif.inb), 32'(b));
      chk("en_rise", 32'(gif.AndEnable), 1);
      chk("busy", 32'(in_ready), 0);
      seen_ina[gif.ina] = 1'b1;
      en_n = 1;
      lat  = 0;
      while (!res_valid && lat < 10) begin
         tick();
         lat++;
         if (gif.AndEnable) begin
            en_n++;
            chk("ina_hold", 32'(gif.ina), 32'(ea));
            chk("inb_hold", 32'(gif.inb), 32'(eb));
         end
      end
      chk("latency", lat, 4);
      chk("en_cycles", en_n, 3);
      chk("res_out", 32'(res_out), 32'(a & b));
      chk("res_shares", 32'(res_shares), 32'(es));
      chk("res_xor", 32'(^res_shares), 32'(a & b));
      chk("bus_clear", 32'({gif.ina, gif.inb, gif.rin}), 0);
      chk("lfsr_nz", 32'(dut.lfsr_q != 32'd0), 1);
      sh = res_shares;
      ro = res_out;
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_valid", 32'(res_valid), 1);
         chk("hold_data", 32'({res_out, res_shares}), 32'({ro, sh}));
         chk("hold_busy", 32'(in_ready), 0);
      end
      res_ready = 1'b1;
      tick();
      chk("ret_idle", 32'(in_ready), 1);
      chk("ret_valid", 32'(res_valid), 0);
   endtask

   initial begin
      int         lat;
      logic [1:0] p;
      do_reset(0);
      do_reset(2);

      for (int i = 0; i < 4; i++) begin
         p = 2'(i);
         do_op(p[1], p[0], 0, 0);
      end

      do_op(1'b1, 1'b0, 5, 0);
      do_op(1'b1, 1'b1, 5, 1);

      for (int i = 0; i < 200; i++) do_op(1'b1, 1'b1, 0, 0);
      chk("ina_varies", 32'($countones(seen_ina) > 1), 1);

      // Reset while the gadget counter sits at 2.
      res_ready = 1'b1;
      in_a      = 1'b1;
      in_b      = 1'b1;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("mid_en", 32'(gif.AndEnable), 0);
      chk("mid_valid", 32'(res_valid), 0);
      rst = 1'b0;
      wait_flush(1, 0, 0);
      do_op(1'b1, 1'b1, 0, 0);

      // Gadget withholds done at the check.
      force_nd = 1'b1;
      in_a     = 1'b1;
      in_b     = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!sync_err && !res_valid && lat < 10) begin
         tick();
         lat++;
      end
      chk("serr_lat", lat, 4);
      chk("serr", 32'(sync_err), 1);
      chk("serr_novalid", 32'(res_valid), 0);
      force_nd = 1'b0;
      tick();
      chk("serr_pulse", 32'(sync_err), 0);
      chk("serr_flush_en", 32'(gif.AndEnable), 1);
      wait_flush(3, 1, 1);
      do_op(1'b1, 1'b1, 0, 0);

      for (int i = 0; i < 30; i++)
         do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "timeout");
   end
endmodule
